// File: rtl/led_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_sequencer_if
//  Description : Control and LED signal bundle for led_sequencer. The master
//                side drives enable/mode/load/pattern; the slave side (the
//                sequencer) drives the eight LED lines and the step tick.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_sequencer_if;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] pat_in;
    logic       LED0;
    logic       LED1;
    logic       LED2;
    logic       LED3;
    logic       LED4;
    logic       LED5;
    logic       LED6;
    logic       LED7;
    logic       tick;

    modport master (
        output en, mode, load, pat_in,
        input  LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7, tick
    );

    modport slave (
        input  en, mode, load, pat_in,
        output LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7, tick
    );
endinterface
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_sequencer
//  Description : Eight-LED pattern sequencer. A prescaler counts enabled
//                clocks and every DIV_MAX of them advances the registered
//                pattern according to the selected mode (static, rotate,
//                ping-pong, blink). A one-cycle tick accompanies each step.
//  Revision    : 1.0  initial release
// ============================================================================
module led_sequencer #(
    parameter int         DIV_WIDTH = 22,
    parameter int         DIV_MAX   = 3000000,
    parameter logic [7:0] RESET_PAT = 8'h33
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    led_sequencer_if.slave  bus
);

    // Last count value before the prescaler wraps and a step occurs.
    localparam logic [DIV_WIDTH-1:0] c_CNT_LAST = DIV_WIDTH'(DIV_MAX - 1);
    localparam logic [DIV_WIDTH-1:0] c_CNT_ONE  = DIV_WIDTH'(1);

    localparam logic [1:0] c_MODE_STATIC = 2'd0;
    localparam logic [1:0] c_MODE_ROTATE = 2'd1;
    localparam logic [1:0] c_MODE_PINGPONG = 2'd2;
    localparam logic [1:0] c_MODE_BLINK  = 2'd3;

    // Ping-pong travel direction; "left" moves the lit bit toward LED7.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [7:0]           r_led_q;
    logic [7:0]           r_base;
    dir_t                 r_dir;
    logic                 r_tick;

    logic                 w_step;
    logic [DIV_WIDTH-1:0] w_cnt_next;
    logic [7:0]           w_step_led;
    dir_t                 w_step_dir;

    // Prescaler wrap detection and next count value.
    always_comb begin
        w_step     = bus.en && (r_cnt == c_CNT_LAST);
        w_cnt_next = w_step ? '0 : (r_cnt + c_CNT_ONE);
    end

    // Pattern and direction that a step would produce in the current mode.
    always_comb begin
        w_step_led = r_led_q;
        w_step_dir = r_dir;
        case (bus.mode)
            c_MODE_STATIC: begin
                w_step_led = r_led_q;
            end
            c_MODE_ROTATE: begin
                w_step_led = {r_led_q[6:0], r_led_q[7]};
            end
            c_MODE_PINGPONG: begin
                // An all-zero pattern shifts to zero either way, so it stays dark.
                if (r_dir == DIR_LEFT) begin
                    if (r_led_q[7]) begin
                        w_step_dir = DIR_RIGHT;
                        w_step_led = r_led_q >> 1;
                    end else begin
                        w_step_led = r_led_q << 1;
                    end
                end else begin
                    if (r_led_q[0]) begin
                        w_step_dir = DIR_LEFT;
                        w_step_led = r_led_q << 1;
                    end else begin
                        w_step_led = r_led_q >> 1;
                    end
                end
            end
            c_MODE_BLINK: begin
                w_step_led = (r_led_q == 8'h00) ? r_base : 8'h00;
            end
            default: begin
                w_step_led = r_led_q;
            end
        endcase
    end

    // State update: reset beats load, load beats a coincident step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_led_q <= RESET_PAT;
            r_base  <= RESET_PAT;
            r_dir   <= DIR_LEFT;
            r_tick  <= 1'b0;
        end else if (bus.load) begin
            r_cnt   <= '0;
            r_led_q <= bus.pat_in;
            r_base  <= bus.pat_in;
            r_dir   <= DIR_LEFT;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_step;
            if (bus.en) begin
                r_cnt <= w_cnt_next;
            end
            if (w_step) begin
                r_led_q <= w_step_led;
                r_dir   <= w_step_dir;
            end
        end
    end

    assign bus.LED0 = r_led_q[0];
    assign bus.LED1 = r_led_q[1];
    assign bus.LED2 = r_led_q[2];
    assign bus.LED3 = r_led_q[3];
    assign bus.LED4 = r_led_q[4];
    assign bus.LED5 = r_led_q[5];
    assign bus.LED6 = r_led_q[6];
    assign bus.LED7 = r_led_q[7];
    assign bus.tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_sequencer
//  Description : Self-checking bench for led_sequencer with DIV_MAX=4.
//                Table of per-mode step sequences, hand-written corner
//                sequences, then random traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_sequencer;

    localparam int DIV_WIDTH = 2;
    localparam int DIV_MAX   = 4;

    logic clk = 1'b0;
    logic rstn;

    led_sequencer_if bus ();

    led_sequencer #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX),
        .RESET_PAT (8'h33)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] leds;
    assign leds = {bus.LED7, bus.LED6, bus.LED5, bus.LED4,
                   bus.LED3, bus.LED2, bus.LED1, bus.LED0};

    int total = 0;
    int bad   = 0;

    // Reference model: counts enabled edges since the last reset/load and
    // applies the mode rules whenever that count reaches a multiple of DIV_MAX.
    int         m_since;
    logic [7:0] m_led;
    logic [7:0] m_base;
    bit         m_right;
    bit         m_tick;

    task automatic model_edge(input logic r, input logic e, input logic [1:0] m,
                              input logic l, input logic [7:0] p);
        if (!r) begin
            m_since = 0; m_led = 8'h33; m_base = 8'h33; m_right = 0; m_tick = 0;
        end else if (l) begin
            m_since = 0; m_led = p; m_base = p; m_right = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (e) begin
                m_since = m_since + 1;
                if (m_since % DIV_MAX == 0) begin
                    m_tick = 1;
                    case (m)
                        2'd1: m_led = {m_led[6:0], m_led[7]};
                        2'd2: begin
                            if (m_led != 8'h00) begin
                                if (!m_right) begin
                                    if (m_led[7]) begin m_right = 1; m_led = m_led >> 1; end
                                    else m_led = m_led << 1;
                                end else begin
                                    if (m_led[0]) begin m_right = 0; m_led = m_led << 1; end
                                    else m_led = m_led >> 1;
                                end
                            end
                        end
                        2'd3: m_led = (m_led == 8'h00) ? m_base : 8'h00;
                        default: ;
                    endcase
                end
            end
        end
    endtask

    // Drive one set of inputs across a rising edge, sample 1 ns after it.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic l, input logic [7:0] p);
        rstn       = r;
        bus.en     = e;
        bus.mode   = m;
        bus.load   = l;
        bus.pat_in = p;
        @(posedge clk);
        #1;
        model_edge(r, e, m, l, p);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]      pat;
        logic [1:0]      mode;
        logic [0:3][7:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] pp [16];
        logic [7:0] prev;
        int         ticks;

        // LED value after each of four consecutive steps following a load.
        vecs[0]  = '{8'h81, 2'd1, {8'h03, 8'h06, 8'h0C, 8'h18}};
        vecs[1]  = '{8'h01, 2'd2, {8'h02, 8'h04, 8'h08, 8'h10}};
        vecs[2]  = '{8'h40, 2'd2, {8'h80, 8'h40, 8'h20, 8'h10}};
        vecs[3]  = '{8'h5A, 2'd3, {8'h00, 8'h5A, 8'h00, 8'h5A}};
        vecs[4]  = '{8'h00, 2'd3, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5]  = '{8'h3C, 2'd0, {8'h3C, 8'h3C, 8'h3C, 8'h3C}};
        vecs[6]  = '{8'h00, 2'd2, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[7]  = '{8'h80, 2'd1, {8'h01, 8'h02, 8'h04, 8'h08}};
        vecs[8]  = '{8'hC3, 2'd2, {8'h61, 8'hC2, 8'h61, 8'hC2}};
        vecs[9]  = '{8'hFF, 2'd1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[10] = '{8'h01, 2'd3, {8'h00, 8'h01, 8'h00, 8'h01}};

        pp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        // Reset held with load and en active: reset must win.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 2'd1, 1'b1, 8'hAA);
            chk("reset_led", leds, 8'h33);
            chk("reset_tick", {7'b0, bus.tick}, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 2'd1, 1'b0, 8'h00);
            chk("frozen_led", leds, 8'h33);
            chk("frozen_tick", {7'b0, bus.tick}, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
            chk("first_step_led", leds, (i == 3) ? 8'h66 : 8'h33);
            chk("first_step_tick", {7'b0, bus.tick}, (i == 3) ? 8'h01 : 8'h00);
        end
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
        chk("tick_width", {7'b0, bus.tick}, 8'h00);

        // Table: load, then four steps of four enabled cycles each.
        for (int v = 0; v < 11; v++) begin
            cyc(1'b1, 1'b1, vecs[v].mode, 1'b1, vecs[v].pat);
            chk("vec_load_led", leds, vecs[v].pat);
            chk("vec_load_tick", {7'b0, bus.tick}, 8'h00);
            prev = vecs[v].pat;
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    cyc(1'b1, 1'b1, vecs[v].mode, 1'b0, 8'h00);
                    if (c < 3) begin
                        chk("vec_hold_led", leds, prev);
                        chk("vec_hold_tick", {7'b0, bus.tick}, 8'h00);
                    end else begin
                        chk("vec_step_led", leds, vecs[v].exp[s]);
                        chk("vec_step_tick", {7'b0, bus.tick}, 8'h01);
                    end
                end
                prev = vecs[v].exp[s];
            end
        end

        // Ping-pong across both ends.
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 8'h01);
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 2'd2, 1'b0, 8'h00);
            chk("pingpong_led", leds, pp[s]);
        end

        // Freeze mid-count, then resume from the held count.
        cyc(1'b1, 1'b1, 2'd1, 1'b1, 8'h11);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 2'd1, 1'b0, 8'h00);
            chk("freeze_led", leds, 8'h11);
            chk("freeze_tick", {7'b0, bus.tick}, 8'h00);
        end
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
        chk("resume1_led", leds, 8'h11);
        chk("resume1_tick", {7'b0, bus.tick}, 8'h00);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
        chk("resume2_led", leds, 8'h22);
        chk("resume2_tick", {7'b0, bus.tick}, 8'h01);

        // Load on the step edge: step lost, counter restarts.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
        chk("pre_collide_led", leds, 8'h22);
        cyc(1'b1, 1'b1, 2'd1, 1'b1, 8'h0F);
        chk("collide_led", leds, 8'h0F);
        chk("collide_tick", {7'b0, bus.tick}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
            chk("post_collide_led", leds, (i == 3) ? 8'h1E : 8'h0F);
            chk("post_collide_tick", {7'b0, bus.tick}, (i == 3) ? 8'h01 : 8'h00);
        end

        // Mode 0 for 12 cycles from a fresh load: constant LEDs, three ticks.
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 8'hA5);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 2'd0, 1'b0, 8'h00);
            chk("static_led", leds, 8'hA5);
            if (bus.tick === 1'b1) ticks = ticks + 1;
        end
        chk("static_ticks", 8'(ticks), 8'd3);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0),
                8'($urandom));
            chk("rand_led", leds, m_led);
            chk("rand_tick", {7'b0, bus.tick}, {7'b0, m_tick});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
# led_sequencer

Drives the eight iCEstick user LEDs (LED0..LED7) from a registered 8-bit pattern. The pattern is advanced by a programmable prescaler tick according to one of four modes: static, rotate, ping-pong or blink. It replaces hard-wired LED assignments at the top level and gives the rest of the design a load/mode/enable interface to the LED resource.

## Interface
- DIV_WIDTH, 22, width of the prescaler counter; must hold DIV_MAX-1.
- DIV_MAX, 3000000, number of enabled clocks per step (4 Hz at 12 MHz); legal range 1..2^DIV_WIDTH.
- RESET_PAT, 8'h33, pattern and base value after reset (LED0, LED1, LED4, LED5 on).

Ports:
- clk  in  1  system clock; single clock domain.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  1 = prescaler runs and steps occur; 0 = freeze counter and LEDs.
- mode  in  2  0 static, 1 rotate-left, 2 ping-pong, 3 blink.
- load  in  1  one-cycle strobe: take pat_in as new pattern and base.
- pat_in  in  8  pattern to load; bit n maps to LEDn.
- LED0..LED7  out  1 each  LEDn = pattern register bit n.
- tick  out  1  registered; high for one cycle after every step edge.

## Operation
- State:
  - cnt[DIV_WIDTH-1:0]
  - led_q[7:0] (drives LEDs)
  - base[7:0] (last loaded pattern)
  - dir (0 = left, 1 = right)
  - tick register
- Reset (rstn=0 at a clk edge): cnt=0, led_q=RESET_PAT, base=RESET_PAT, dir=0, tick=0.
  - Reset overrides load and en.
  - Reset mid-step simply returns all state to these values.
- Prescaler:
  - If en=1: cnt increments; at cnt==DIV_MAX-1 it wraps to 0 and a step occurs on that edge.
  - If en=0: cnt holds and no step occurs.
- Load (load=1, rstn=1):
  - led_q=pat_in, base=pat_in, cnt=0, dir=0.
  - Takes effect regardless of en.
  - Has priority over a coincident step; that step is lost and tick stays 0.
- Step action, selected by mode sampled on the step edge:
  - mode 0: led_q unchanged. tick still pulses.
  - mode 1: led_q = {led_q[6:0], led_q[7]} (rotate toward LED7).
  - mode 2, dir=0:
    - If led_q[7]=1: dir=1 and led_q = led_q>>1.
    - Else: led_q = led_q<<1. Shifts are zero-fill.
  - mode 2, dir=1:
    - If led_q[0]=1: dir=0 and led_q = led_q<<1.
    - Else: led_q = led_q>>1.
  - mode 2, led_q==0: stays 0.
  - mode 3: led_q = (led_q==0) ? base : 8'h00.
    - With base==0 the LEDs stay dark.
- Mode changes:
  - Take effect at the next step with no counter reset.
  - dir is retained across mode changes.
- LED outputs are direct register outputs; there is no combinational path from inputs to LEDs or tick.

## Timing
- Step latency:
  - After reset or load with en held at 1, the first step occurs on the DIV_MAX-th enabled rising edge.
  - The new led_q is visible immediately after that edge.
- tick:
  - Asserted in the cycle immediately after a step edge, coincident with the new LED value.
  - Exactly one cycle wide; at most once per DIV_MAX enabled cycles.
- DIV_MAX=1: a step occurs on every enabled edge and tick stays high continuously while en=1.
- load visibility: LEDs show pat_in from the edge after load, i.e. one-cycle latency.
- Deasserting en freezes cnt mid-count; reasserting resumes from the held count (no restart).

## Test plan
All scenarios use DIV_MAX=4, DIV_WIDTH=2.
- Reset: hold rstn=0 for 3 clocks with load=1 and en=1.
  - Required: LEDs = 8'h33, tick=0, no step for 4 clocks after release if en=0.
- Rotate: load 8'h81, mode=1, en=1.
  - Required: after steps, LEDs = 8'h03, 8'h06, 8'h0C.
  - Required: tick pulses every 4th cycle, width 1.
- Ping-pong: load 8'h01, mode=2.
  - Required: LEDs 02, 04, 08, 10, 20, 40, 80, 40, 20, ..., 01, 02 (direction bounces at both ends).
- Blink and base: load 8'h5A, mode=3.
  - Required: LEDs alternate 00, 5A, 00.
  - Then load 8'h00: LEDs remain 00 across 3 steps.
- Freeze and collision:
  - Drop en after 2 enabled cycles for 10 cycles, then re-raise.
    - Required: the step occurs 2 cycles after re-raise.
  - Assert load on the step edge.
    - Required: LEDs = pat_in, tick=0, the next step 4 enabled cycles later.
- Mode 0: mode=0, en=1 for 12 cycles.
  - Required: LEDs constant, tick pulses 3 times.
